// File: rtl/dmem_bridge.sv
// Purpose: bridges the M-stage aligner's memory-side port to a valid/ready bus, one access at a time.
// Latency: store completes 2 cycles after MREQ and load 3 cycles after it with zero bus wait; each wait cycle adds one.
// Backpressure: STALL holds the M stage until DONE; a per-access timeout forces completion with BUS_ERR.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        MREQ,
    input  logic [29:0] MADDR,
    input  logic [31:0] MDATAO,
    input  logic [3:0]  MWSTB,
    output logic [31:0] MDATAI,
    output logic        STALL,
    output logic        BUS_ERR,
    output logic        BUS_VALID,
    input  logic        BUS_READY,
    output logic [29:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [3:0]  BUS_WSTB,
    input  logic        BUS_RVALID,
    input  logic [31:0] BUS_RDATA
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        tmo_hit;
    logic        is_store;
    logic        bus_valid_q;
    logic        bus_err_q;
    logic [29:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstb_q;
    logic [31:0] mdatai_q;

    // Timeout bookkeeping: the counter only advances while the bus owes us something.
    always_comb begin
        cnt_d    = cnt_q + 8'd1;
        tmo_hit  = ((state_q == S_ADDR) || (state_q == S_RESP)) && (cnt_q == TMO_LIMIT);
        is_store = (bus_wstb_q != 4'b0000);
    end

    // Access sequencer: latches the request, runs address/response phases, owns all bus-side registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bus_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_addr_q  <= 30'd0;
            bus_wdata_q <= 32'd0;
            bus_wstb_q  <= 4'd0;
            mdatai_q    <= 32'd0;
        end else begin
            // Error is a single-cycle pulse aligned with the DONE it caused.
            bus_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MREQ) begin
                        bus_addr_q  <= MADDR;
                        bus_wdata_q <= MDATAO;
                        bus_wstb_q  <= MWSTB;
                        cnt_q       <= 8'd0;
                        bus_valid_q <= 1'b1;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (tmo_hit) begin
                        // Abandon the address phase; a timed-out load reads as zero.
                        bus_valid_q <= 1'b0;
                        bus_err_q   <= 1'b1;
                        if (!is_store) begin
                            mdatai_q <= 32'd0;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (BUS_READY) begin
                            bus_valid_q <= 1'b0;
                            state_q     <= is_store ? S_DONE : S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (tmo_hit) begin
                        bus_err_q <= 1'b1;
                        mdatai_q  <= 32'd0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (BUS_RVALID) begin
                            mdatai_q <= BUS_RDATA;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the very first request cycle already holds the pipeline.
    assign STALL     = MREQ && (state_q != S_DONE);
    assign BUS_VALID = bus_valid_q;
    assign BUS_ERR   = bus_err_q;
    assign BUS_ADDR  = bus_addr_q;
    assign BUS_WDATA = bus_wdata_q;
    assign BUS_WSTB  = bus_wstb_q;
    assign MDATAI    = mdatai_q;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

    typedef struct {
        logic        nrst;
        logic        mreq;
        logic [29:0] maddr;
        logic [31:0] mdatao;
        logic [3:0]  mwstb;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        vld;
        logic        err;
        logic [31:0] md;
        logic [3:0]  wstb;
        logic [29:0] addr;
        logic [31:0] wdata;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic        mreq;
    logic [29:0] maddr;
    logic [31:0] mdatao;
    logic [3:0]  mwstb;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;

    logic [31:0] a_md,   b_md;
    logic        a_stall, b_stall;
    logic        a_err,   b_err;
    logic        a_vld,   b_vld;
    logic [29:0] a_addr,  b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wstb,  b_wstb;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];

    dmem_bridge #(.TIMEOUT(255)) u_dut_a (
        .CLK(clk), .nRST(nrst), .MREQ(mreq), .MADDR(maddr), .MDATAO(mdatao), .MWSTB(mwstb),
        .MDATAI(a_md), .STALL(a_stall), .BUS_ERR(a_err), .BUS_VALID(a_vld), .BUS_READY(rdy),
        .BUS_ADDR(a_addr), .BUS_WDATA(a_wdata), .BUS_WSTB(a_wstb), .BUS_RVALID(rv), .BUS_RDATA(rdata)
    );

    dmem_bridge #(.TIMEOUT(4)) u_dut_b (
        .CLK(clk), .nRST(nrst), .MREQ(mreq), .MADDR(maddr), .MDATAO(mdatao), .MWSTB(mwstb),
        .MDATAI(b_md), .STALL(b_stall), .BUS_ERR(b_err), .BUS_VALID(b_vld), .BUS_READY(rdy),
        .BUS_ADDR(b_addr), .BUS_WDATA(b_wdata), .BUS_WSTB(b_wstb), .BUS_RVALID(rv), .BUS_RDATA(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic n, input logic q, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic r, input logic v, input logic [31:0] rd,
                       input logic e_st, input logic e_vl, input logic e_er, input logic [31:0] e_md,
                       input logic [3:0] e_ws, input logic [29:0] e_ad, input logic [31:0] e_wd);
        vec_t t;
        t.nrst = n;  t.mreq = q;  t.maddr = a;  t.mdatao = d;  t.mwstb = w;
        t.rdy = r;   t.rv = v;    t.rdata = rd;
        t.stall = e_st; t.vld = e_vl; t.err = e_er; t.md = e_md;
        t.wstb = e_ws;  t.addr = e_ad; t.wdata = e_wd;
        tbl.push_back(t);
    endtask

    task automatic drv(input logic q, input logic [29:0] a, input logic [31:0] d, input logic [3:0] w,
                       input logic r, input logic v, input logic [31:0] rd);
        mreq = q; maddr = a; mdatao = d; mwstb = w; rdy = r; rv = v; rdata = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // ---------------- vector table: one row per clock cycle, checked on dut A ----------------
        // reset state
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,4'h0,30'h0,32'h0);
        // zero-wait store
        add(1'b1,1'b1,30'h40,32'h00AB0000,4'h4,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,4'h0,30'h0,32'h0);
        add(1'b1,1'b1,30'h40,32'h00AB0000,4'h4,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,4'h4,30'h40,32'h00AB0000);
        add(1'b1,1'b1,30'h40,32'h00AB0000,4'h4,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,4'h4,30'h40,32'h00AB0000);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,4'h4,30'h40,32'h00AB0000);
        // load with READY at cycle 3, RVALID at cycle 6 (an early RVALID in ADDR is ignored)
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,4'h4,30'h40,32'h00AB0000);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b1,32'hFFFFFFFF, 1'b1,1'b1,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b1,32'h12345678, 1'b1,1'b0,1'b0,32'h0,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h123,32'h0,4'h0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b0,32'h12345678,4'h0,30'h123,32'h0);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h12345678,4'h0,30'h123,32'h0);
        // back-to-back zero-wait store then load
        add(1'b1,1'b1,30'h3FFFFFFF,32'hFFFFFFFF,4'hF,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h12345678,4'h0,30'h123,32'h0);
        add(1'b1,1'b1,30'h3FFFFFFF,32'hFFFFFFFF,4'hF,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h12345678,4'hF,30'h3FFFFFFF,32'hFFFFFFFF);
        add(1'b1,1'b1,30'h3FFFFFFF,32'hFFFFFFFF,4'hF,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h12345678,4'hF,30'h3FFFFFFF,32'hFFFFFFFF);
        add(1'b1,1'b1,30'h2,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h12345678,4'hF,30'h3FFFFFFF,32'hFFFFFFFF);
        add(1'b1,1'b1,30'h2,32'h0,4'h0,1'b1,1'b0,32'h0,          1'b1,1'b1,1'b0,32'h12345678,4'h0,30'h2,32'h0);
        add(1'b1,1'b1,30'h2,32'h0,4'h0,1'b0,1'b1,32'hCAFEF00D,   1'b1,1'b0,1'b0,32'h12345678,4'h0,30'h2,32'h0);
        add(1'b1,1'b1,30'h2,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h2,32'h0);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h2,32'h0);
        // flush: MREQ drops in ADDR, new store raised during RESP waits for IDLE
        add(1'b1,1'b1,30'h55,32'h0,4'h0,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h2,32'h0);
        add(1'b1,1'b1,30'h55,32'h0,4'h0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'hCAFEF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b1,1'b0,32'h0,          1'b0,1'b1,1'b0,32'hCAFEF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b0,1'b1,32'h0BADF00D, 1'b1,1'b0,1'b0,32'hCAFEF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0BADF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,32'h0BADF00D,4'h0,30'h55,32'h0);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b1,1'b0,32'h0,  1'b1,1'b1,1'b0,32'h0BADF00D,4'h3,30'h66,32'h11223344);
        add(1'b1,1'b1,30'h66,32'h11223344,4'h3,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0BADF00D,4'h3,30'h66,32'h11223344);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h0BADF00D,4'h3,30'h66,32'h11223344);
        // reset asserted while waiting in RESP, then a fresh load
        add(1'b1,1'b1,30'h9,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h0BADF00D,4'h3,30'h66,32'h11223344);
        add(1'b1,1'b1,30'h9,32'h0,4'h0,1'b1,1'b0,32'h0,          1'b1,1'b1,1'b0,32'h0BADF00D,4'h0,30'h9,32'h0);
        add(1'b1,1'b1,30'h9,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h0BADF00D,4'h0,30'h9,32'h0);
        add(1'b0,1'b1,30'h9,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h0,4'h0,30'h0,32'h0);
        add(1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h0,4'h0,30'h0,32'h0);
        add(1'b1,1'b1,30'hA,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h0,4'h0,30'h0,32'h0);
        add(1'b1,1'b1,30'hA,32'h0,4'h0,1'b1,1'b0,32'h0,          1'b1,1'b1,1'b0,32'h0,4'h0,30'hA,32'h0);
        add(1'b1,1'b1,30'hA,32'h0,4'h0,1'b0,1'b1,32'h5A5A0F0F,   1'b1,1'b0,1'b0,32'h0,4'h0,30'hA,32'h0);
        add(1'b1,1'b1,30'hA,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h5A5A0F0F,4'h0,30'hA,32'h0);
        add(1'b1,1'b0,30'h0,32'h0,4'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h5A5A0F0F,4'h0,30'hA,32'h0);

        // ---------------- apply table ----------------
        nrst = 1'b0;
        drv(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) step();
        for (int i = 0; i < tbl.size(); i++) begin
            nrst = tbl[i].nrst;
            drv(tbl[i].mreq, tbl[i].maddr, tbl[i].mdatao, tbl[i].mwstb, tbl[i].rdy, tbl[i].rv, tbl[i].rdata);
            @(negedge clk);
            tests++;
            if ({a_stall, a_vld, a_err, a_md, a_wstb, a_addr, a_wdata} !==
                {tbl[i].stall, tbl[i].vld, tbl[i].err, tbl[i].md, tbl[i].wstb, tbl[i].addr, tbl[i].wdata}) begin
                fails++;
                $display("FAIL row%0d: got stall=%b vld=%b err=%b md=%h wstb=%h addr=%h wdata=%h expected stall=%b vld=%b err=%b md=%h wstb=%h addr=%h wdata=%h",
                         i, a_stall, a_vld, a_err, a_md, a_wstb, a_addr, a_wdata,
                         tbl[i].stall, tbl[i].vld, tbl[i].err, tbl[i].md, tbl[i].wstb, tbl[i].addr, tbl[i].wdata);
            end
            step();
        end

        // ---------------- timeout on dut B (TIMEOUT=4) ----------------
        nrst = 1'b0;
        drv(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        step();
        nrst = 1'b1;
        // zero-wait load so MDATAI holds a nonzero value before the timeout
        drv(1'b1, 30'h7, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        step();
        drv(1'b1, 30'h7, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        step();
        drv(1'b1, 30'h7, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A5A5A5);
        step();
        drv(1'b1, 30'h7, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("tmo_pre_md", b_md, 32'hA5A5A5A5);
        chk("tmo_pre_stall", 32'(b_stall), 32'h0);
        step();
        // load that is never accepted: cycle 0 here
        drv(1'b1, 30'h8, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("tmo_c0_stall", 32'(b_stall), 32'h1);
        step();
        begin
            int done_cyc;
            int vld_bad;
            done_cyc = -1;
            vld_bad  = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (b_err) begin
                    done_cyc = n;
                    break;
                end
                if (!b_vld) vld_bad++;
                step();
            end
            chk("tmo_done_cycle", 32'(done_cyc), 32'd6);
            chk("tmo_vld_held", 32'(vld_bad), 32'd0);
            chk("tmo_done_vld", 32'(b_vld), 32'h0);
            chk("tmo_done_md", b_md, 32'h0);
            chk("tmo_done_stall", 32'(b_stall), 32'h0);
        end
        step();
        drv(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h99999999);
        @(negedge clk);
        chk("tmo_err_pulse", 32'(b_err), 32'h0);
        chk("tmo_late_rv_md0", b_md, 32'h0);
        step();
        @(negedge clk);
        chk("tmo_late_rv_md1", b_md, 32'h0);
        chk("tmo_idle_vld", 32'(b_vld), 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Multi-cycle data-memory bridge between the M-stage data aligner's memory-side port and a handshaked memory bus. It latches one lane-formatted load or store request, runs a valid/ready address phase and, for loads, a response phase. It stalls the pipeline until the access completes and returns read data in the aligner's byte-lane layout. A per-access timeout converts a hung bus into an error-flagged completion, so the core never deadlocks.

## Interface
- TIMEOUT, 255, max cycles spent in ADDR+RESP before forced completion; legal range 1..255
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  reset, asynchronous, active-low
- MREQ  in  1  M-stage access request (load or store), level
- MADDR  in  30  word address [31:2]
- MDATAO  in  32  store data, already lane-placed
- MWSTB  in  4  byte write strobe; 4'b0000 with MREQ=1 means load
- MDATAI  out  32  load data to aligner, lane layout unchanged from bus
- STALL  out  1  hold M stage
- BUS_ERR  out  1  one-cycle pulse: current access timed out
- BUS_VALID  out  1  address-phase valid
- BUS_READY  in  1  address-phase accept
- BUS_ADDR  out  30  registered word address
- BUS_WDATA  out  32  registered store data
- BUS_WSTB  out  4  registered strobe (0000 = read)
- BUS_RVALID  in  1  read-data valid
- BUS_RDATA  in  32  read data

## Operation
- FSM states: IDLE, ADDR, RESP, DONE.
- IDLE: if MREQ=1, capture MADDR/MDATAO/MWSTB into BUS_* registers, clear timeout counter, go to ADDR. Otherwise stay.
- ADDR: BUS_VALID=1, BUS_* held stable.
  - On BUS_READY=1: store (WSTB≠0) goes to DONE; load goes to RESP.
- RESP: BUS_VALID=0. On BUS_RVALID=1, capture BUS_RDATA into MDATAI register and go to DONE.
- DONE: one cycle, STALL=0, pipeline advances at this edge; next state IDLE unconditionally.
- STALL = MREQ & (state ≠ DONE), combinational. Cycle 0 of a request is therefore already stalled.
- Timeout: an 8-bit counter increments each cycle in ADDR or RESP. When it reaches TIMEOUT:
  - go to DONE and drop BUS_VALID;
  - a load writes MDATAI=32'h0;
  - BUS_ERR=1 during that DONE cycle only.
- MDATAI holds the last completed load value. Stores and idle cycles do not change it.
- Byte lanes and strobes pass through unmodified; the bridge performs no alignment or endian swap.
- BUS_RVALID/BUS_RDATA are ignored outside RESP, including late responses after a timeout.
- MREQ must remain high with stable MADDR/MDATAO/MWSTB from assertion through DONE. If MREQ falls mid-access (flush), the bus transaction still completes through DONE and the result is discarded by the core. No new request is accepted until the FSM returns to IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, BUS_VALID=0, BUS_ADDR=0, BUS_WDATA=0, BUS_WSTB=0, MDATAI=0, BUS_ERR=0, counter=0.
- Reset asserted mid-transaction drops BUS_VALID immediately. The bus slave must tolerate an abandoned request.
- Zero-wait store: MREQ at cycle 0 (IDLE), BUS_VALID at cycle 1 with READY, DONE at cycle 2. STALL is high in cycles 0–1.
- Zero-wait load: BUS_VALID at cycle 1, RVALID at cycle 2 (earliest legal is the cycle after acceptance), DONE/MDATAI valid at cycle 3.
- Each cycle READY or RVALID is late adds one stall cycle.
- Back-to-back: the next request seen in the IDLE cycle after DONE. Minimum spacing is 3 cycles per store and 4 cycles per load.
- Timeout DONE occurs TIMEOUT+1 cycles after entering ADDR.

## Test plan
- Store: MADDR=30'h0000_0040, MDATAO=32'h00AB_0000, MWSTB=4'b0100, READY=1 -> cycle 1 BUS_VALID=1 with BUS_WSTB=0100; STALL low only at cycle 2; MDATAI unchanged.
- Load with waits: MWSTB=0, READY at cycle 3, RVALID with 32'h1234_5678 at cycle 6 -> DONE at cycle 7, MDATAI=32'h1234_5678, STALL high cycles 0–6.
- Back-to-back store then load (both zero-wait) -> second BUS_VALID exactly at cycle 4; total stall-free completion at cycles 2 and 6.
- Timeout: TIMEOUT=4, READY never asserted -> BUS_VALID drops; DONE at cycle 6 with BUS_ERR=1 for one cycle, MDATAI=0. Later RVALID=1 is ignored and MDATAI stays 0.
- Reset mid-RESP: assert nRST=0 while waiting for RVALID -> BUS_VALID=0, MDATAI=0, STALL=MREQ immediately. After release, a new load completes normally.
- Flush: MREQ falls during ADDR -> transaction still reaches DONE. A new MREQ raised during RESP is not issued until after DONE.
